// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, hazard stall, branch redirect and the
// IF/ID pipeline register. The instruction memory is external and synchronous:
// it samples pc_out at a posedge and presents the word on instr_in after the
// following negedge, so instr_in at any posedge belongs to pc_mem.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] instr_in,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        misalign
);

  localparam logic [31:0] MEM_SIZE = 32'(IMEM_BYTES);

  // Sequential successor of an address, wrapping at the end of memory.
  function automatic logic [31:0] wrap_plus4(input logic [31:0] addr);
    logic [31:0] sum;
    sum = addr + 32'd4;
    if (sum >= MEM_SIZE) begin
      sum = sum - MEM_SIZE;
    end
    return sum;
  endfunction

  logic [31:0] pc_q;       // next address to issue
  logic [31:0] pc_mem;     // address the memory sampled at the last posedge
  logic        mem_valid;  // pc_mem is a live (non-squashed) fetch
  logic [31:0] target_aligned;

  // Redirect address: word-aligned and folded into the memory range.
  always_comb begin
    target_aligned = {branch_target[31:2], 2'b00} % MEM_SIZE;
  end

  // During a stall the memory re-fetches the in-flight address so that
  // instr_in still belongs to pc_mem when the stall releases.
  always_comb begin
    pc_out = (stall && !branch_taken) ? pc_mem : pc_q;
  end

  // IF/ID address successor, shown to the decode stage.
  always_comb begin
    if_id_pc_plus4 = wrap_plus4(if_id_pc);
  end

  // PC and IF/ID pipeline state; branch beats stall beats normal advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      pc_mem      <= RESET_PC;
      mem_valid   <= 1'b0;
      if_id_instr <= 32'h0;
      if_id_pc    <= 32'h0;
      if_id_valid <= 1'b0;
    end else if (branch_taken) begin
      // The fetch sampled at this edge (old pc_q) is dead, as is the one
      // completing now; both are squashed via the valid bits.
      pc_q        <= target_aligned;
      pc_mem      <= pc_q;
      mem_valid   <= 1'b0;
      if_id_instr <= 32'h0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      pc_mem      <= pc_q;
      pc_q        <= wrap_plus4(pc_q);
      mem_valid   <= 1'b1;
      if_id_instr <= instr_in;
      if_id_pc    <= pc_mem;
      if_id_valid <= mem_valid;
    end
  end

  // One-cycle flag for a redirect whose target was not word-aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign <= 1'b0;
    end else begin
      misalign <= branch_taken && (branch_target[1:0] != 2'b00);
    end
  end

endmodule
